fetch_pc_unit: RTL and testbench

- Owns the word-addressed program counter (PC) and drives sequential instruction fetch.
- Consumes the resolved-branch interface (jump, next, jal, jalr) that the execute stage produces.
- On a taken redirect it loads the target PC and squashes wrong-path instructions in the IF/ID and ID/EX registers for a fixed number of cycles.
- Also maintains saturating redirect performance counters.

---
 rtl/fetch_pc_unit.sv | 103 ++++++++++
 tb/tb_fetch_pc_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the word-addressed fetch PC, applies execute-stage
// redirects, squashes the wrong path for FLUSH_CYCLES cycles, and keeps
// saturating redirect counters. Every output comes straight from a flop.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             jump,
   input  logic [31:0]      next,
   input  logic             jal,
   input  logic             jalr,
   output logic [31:0]      pc,
   output logic             pc_valid,
   output logic             flush,
   output logic             busy_flush,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] jump_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   // 4 bits covers the full 1..15 flush range
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t           state, state_d;
   logic [3:0]       fcnt, fcnt_d;
   logic [31:0]      pc_d;
   logic             pc_valid_d, flush_d, busy_flush_d;
   logic [CNT_W-1:0] redirect_cnt_d, jump_cnt_d;

   // next-state and next-output decode; everything defaults to hold
   always_comb begin
      state_d        = state;
      fcnt_d         = fcnt;
      pc_d           = pc;
      pc_valid_d     = pc_valid;
      flush_d        = flush;
      busy_flush_d   = busy_flush;
      redirect_cnt_d = redirect_cnt;
      jump_cnt_d     = jump_cnt;
      case (state)
         BOOT: begin
            // first fetch is RESET_PC itself, so pc is not advanced here
            state_d    = RUN;
            pc_valid_d = 1'b1;
         end
         RUN: begin
            if (jump) begin
               pc_d         = next;
               flush_d      = 1'b1;
               busy_flush_d = 1'b1;
               fcnt_d       = FLUSH_LOAD;
               state_d      = FLUSH;
               if (redirect_cnt != '1) redirect_cnt_d = redirect_cnt + CNT_W'(1);
               if ((jal | jalr) && jump_cnt != '1) jump_cnt_d = jump_cnt + CNT_W'(1);
            end else if (!stall) begin
               pc_d = pc + 32'd1;
            end
         end
         FLUSH: begin
            // jumps here come from squashed instructions and are dropped;
            // the flush window runs on the clock, not on stall
            if (!stall) pc_d = pc + 32'd1;
            if (fcnt == 4'd0) begin
               flush_d      = 1'b0;
               busy_flush_d = 1'b0;
               state_d      = RUN;
            end else begin
               fcnt_d = fcnt - 4'd1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // state and output registers, async active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= BOOT;
         fcnt         <= 4'd0;
         pc           <= RESET_PC;
         pc_valid     <= 1'b0;
         flush        <= 1'b0;
         busy_flush   <= 1'b0;
         redirect_cnt <= '0;
         jump_cnt     <= '0;
      end else begin
         state        <= state_d;
         fcnt         <= fcnt_d;
         pc           <= pc_d;
         pc_valid     <= pc_valid_d;
         flush        <= flush_d;
         busy_flush   <= busy_flush_d;
         redirect_cnt <= redirect_cnt_d;
         jump_cnt     <= jump_cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench: unit A (RESET_PC=0x10, 2-cycle flush, 16-bit counters)
// covers fetch/stall/redirect/wrap/reset; unit B (1-cycle flush, 2-bit
// counters) covers the minimum flush and counter saturation.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall, jump, jal, jalr;
   logic [31:0] next;
   logic [31:0] pc;
   logic        pc_valid, flush, busy_flush;
   logic [15:0] redirect_cnt, jump_cnt;

   logic        b_stall, b_jump, b_jal, b_jalr;
   logic [31:0] b_next;
   logic [31:0] b_pc;
   logic        b_pc_valid, b_flush, b_busy_flush;
   logic [1:0]  b_redirect_cnt, b_jump_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(32'h10), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .jump(jump), .next(next),
      .jal(jal), .jalr(jalr), .pc(pc), .pc_valid(pc_valid), .flush(flush),
      .busy_flush(busy_flush), .redirect_cnt(redirect_cnt), .jump_cnt(jump_cnt)
   );

   fetch_pc_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .stall(b_stall), .jump(b_jump), .next(b_next),
      .jal(b_jal), .jalr(b_jalr), .pc(b_pc), .pc_valid(b_pc_valid), .flush(b_flush),
      .busy_flush(b_busy_flush), .redirect_cnt(b_redirect_cnt), .jump_cnt(b_jump_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // one rising edge, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      stall = 0; jump = 0; jal = 0; jalr = 0; next = '0;
      b_stall = 0; b_jump = 0; b_jal = 0; b_jalr = 0; b_next = '0;
      #12;
      chk("rst_pc", pc, 32'h10);
      chk("rst_valid", pc_valid, 0);
      chk("rst_flush", flush, 0);
      chk("rst_busy", busy_flush, 0);
      chk("rst_rcnt", redirect_cnt, 0);
      chk("rst_jcnt", jump_cnt, 0);
      chk("rst_b_pc", b_pc, 0);

      // boot then sequential fetch
      reset_n = 1'b1;
      step(); chk("boot_valid", pc_valid, 1); chk("boot_pc", pc, 32'h10);
      step(); chk("seq_pc1", pc, 32'h11);
      step(); chk("seq_pc2", pc, 32'h12); chk("seq_flush", flush, 0);

      // plain redirect (no jal/jalr) to reach 0x20
      jump = 1; next = 32'h1E;
      step(); chk("r1_pc", pc, 32'h1E); chk("r1_flush", flush, 1);
      chk("r1_busy", busy_flush, 1); chk("r1_rcnt", redirect_cnt, 1); chk("r1_jcnt", jump_cnt, 0);
      jump = 0;
      step(); chk("r1_pc1", pc, 32'h1F); chk("r1_flush1", flush, 1);
      step(); chk("r1_pc2", pc, 32'h20); chk("r1_flush2", flush, 0); chk("r1_busy2", busy_flush, 0);

      // stall holds pc for 3 cycles
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_pc", pc, 32'h20); chk("stall_flush", flush, 0);
      end
      stall = 0;
      step(); chk("unstall_pc", pc, 32'h21);

      // jal redirect to 0x100
      jump = 1; next = 32'h100; jal = 1;
      step(); chk("jal_pc", pc, 32'h100); chk("jal_flush", flush, 1);
      chk("jal_rcnt", redirect_cnt, 2); chk("jal_jcnt", jump_cnt, 1);
      jump = 0; jal = 0;
      step(); chk("jal_pc1", pc, 32'h101); chk("jal_flush1", flush, 1);
      step(); chk("jal_pc2", pc, 32'h102); chk("jal_flush2", flush, 0);

      // jump held 3 cycles: only the first is taken
      jump = 1; next = 32'h40; jalr = 1;
      step(); chk("hold_pc0", pc, 32'h40); chk("hold_rcnt0", redirect_cnt, 3); chk("hold_jcnt0", jump_cnt, 2);
      step(); chk("hold_pc1", pc, 32'h41); chk("hold_flush1", flush, 1);
      step(); chk("hold_pc2", pc, 32'h42); chk("hold_flush2", flush, 0); chk("hold_rcnt2", redirect_cnt, 3);
      jump = 0; jalr = 0;
      step(); chk("hold_pc3", pc, 32'h43); chk("hold_rcnt3", redirect_cnt, 3);

      // jump beats stall; stall holds pc inside flush
      jump = 1; stall = 1; next = 32'h80;
      step(); chk("js_pc", pc, 32'h80); chk("js_flush", flush, 1); chk("js_rcnt", redirect_cnt, 4);
      jump = 0;
      step(); chk("js_pc1", pc, 32'h80); chk("js_flush1", flush, 1);
      stall = 0;
      step(); chk("js_pc2", pc, 32'h81); chk("js_flush2", flush, 0);

      // pc wrap 0xFFFF_FFFF -> 0 while in RUN
      jump = 1; next = 32'hFFFF_FFFD;
      step(); chk("wrap_pc0", pc, 32'hFFFF_FFFD);
      jump = 0;
      step(); chk("wrap_pc1", pc, 32'hFFFF_FFFE);
      step(); chk("wrap_pc2", pc, 32'hFFFF_FFFF); chk("wrap_busy2", busy_flush, 0);
      step(); chk("wrap_pc3", pc, 32'h0);

      // async reset in the middle of a flush
      jump = 1; next = 32'h200;
      step(); chk("ar_flush", flush, 1);
      jump = 0;
      #2 reset_n = 1'b0;
      #1;
      chk("ar_pc", pc, 32'h10); chk("ar_flush0", flush, 0); chk("ar_busy0", busy_flush, 0);
      chk("ar_valid0", pc_valid, 0); chk("ar_rcnt", redirect_cnt, 0);
      #3 reset_n = 1'b1;
      step(); chk("ar_boot_pc", pc, 32'h10); chk("ar_boot_valid", pc_valid, 1); chk("ar_boot_flush", flush, 0);
      step(); chk("ar_seq_pc", pc, 32'h11);

      // unit B: one-cycle flush and 2-bit saturating counters
      for (int i = 0; i < 4; i++) begin
         b_jump = 1; b_next = 32'h100 * (i + 1); b_jal = (i % 2 == 0); b_jalr = (i % 2 == 1);
         step();
         chk("b_pc", b_pc, 32'h100 * (i + 1)); chk("b_flush", b_flush, 1);
         chk("b_rcnt", b_redirect_cnt, (i < 3) ? i + 1 : 3);
         chk("b_jcnt", b_jump_cnt, (i < 3) ? i + 1 : 3);
         b_jump = 0; b_jal = 0; b_jalr = 0;
         step();
         chk("b_pc1", b_pc, 32'h100 * (i + 1) + 1); chk("b_flush1", b_flush, 0);
      end
      // jump on the flush-exit edge is dropped
      b_jump = 1; b_next = 32'h50;
      step(); chk("b_exit_pc0", b_pc, 32'h50);
      step(); chk("b_exit_pc1", b_pc, 32'h51); chk("b_exit_flush1", b_flush, 0);
      b_jump = 0;
      step(); chk("b_exit_pc2", b_pc, 32'h52); chk("b_exit_rcnt", b_redirect_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
